// File: rtl/ahb_arb_pkg.sv
// Shared types and AHB transfer-type encodings for the master arbiter.
package ahb_arb_pkg;
    typedef enum logic [1:0] {PARK, GRANT, HANDOVER} arb_state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;
endpackage

// File: rtl/rr_pick4.sv
// Four-way round-robin picker: first set bit of req searching upward from
// last+1 with wrap, so the previous owner has the lowest priority.
module rr_pick4 (
    input  logic [3:0] req,
    input  logic [1:0] last,
    output logic [1:0] pick,
    output logic       any
);
    always_comb begin
        pick = last;
        // Walk from lowest to highest priority so the last hit wins.
        for (int i = 4; i >= 1; i--) begin
            if (req[last + 2'(i)]) pick = last + 2'(i);
        end
    end

    assign any = |req;
endmodule

// File: rtl/ahb_master_arbiter.sv
// Round-robin master-select generator for the four-port AHB master mux;
// switches owners only at IDLE/HREADY boundaries and parks on a default master.
module ahb_master_arbiter
    import ahb_arb_pkg::*;
#(
    parameter logic [3:0] M_ENABLE       = 4'hF,
    parameter int         DEFAULT_MASTER = 0,
    parameter int         MAX_HOLD       = 16
) (
    input  logic       HCLK,
    input  logic       HRESET,
    input  logic [3:0] HREQ,
    input  logic [1:0] HTRANS,
    input  logic       HREADY,
    output logic [1:0] HMSEL,
    output logic [3:0] HGRANT,
    output logic       ARB_PARKED
);
    localparam int             CW       = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;
    localparam logic [CW-1:0]  HOLD_MAX = CW'(MAX_HOLD);
    localparam logic [1:0]     DEF_SEL  = 2'(DEFAULT_MASTER);

    arb_state_t    state_q, state_d;
    logic [1:0]    hmsel_q, hmsel_d;
    logic [3:0]    hgrant_q, hgrant_d;
    logic          parked_q, parked_d;
    logic [CW-1:0] hold_q, hold_d;

    logic [3:0] req_v;
    logic [1:0] pick;
    logic       any, arb_ok, others, expired;

    assign req_v  = HREQ & M_ENABLE;
    assign arb_ok = HREADY && (HTRANS == HTRANS_IDLE);
    assign others = |(req_v & ~(4'b0001 << hmsel_q));

    generate
        if (MAX_HOLD == 0) begin : g_unlimited
            assign expired = 1'b0;
        end else begin : g_limited
            assign expired = (hold_q >= HOLD_MAX);
        end
    endgenerate

    rr_pick4 u_pick (
        .req  (req_v),
        .last (hmsel_q),
        .pick (pick),
        .any  (any)
    );

    always_comb begin
        state_d = state_q;
        hmsel_d = hmsel_q;
        hold_d  = hold_q;
        case (state_q)
            PARK: begin
                if (arb_ok && any) begin
                    hmsel_d = pick;
                    hold_d  = '0;
                    state_d = (pick == hmsel_q) ? GRANT : HANDOVER;
                end
            end
            GRANT: begin
                if (hold_q != HOLD_MAX) hold_d = hold_q + 1'b1;
                if (arb_ok) begin
                    if (!HREQ[hmsel_q]) begin
                        hmsel_d = any ? pick : DEF_SEL;
                        hold_d  = '0;
                        state_d = HANDOVER;
                    end else if (expired && others) begin
                        hmsel_d = pick;
                        hold_d  = '0;
                        state_d = HANDOVER;
                    end
                end
            end
            HANDOVER: begin
                // The mux adopts the new select on this HREADY edge.
                if (HREADY) state_d = req_v[hmsel_q] ? GRANT : PARK;
            end
            default: state_d = PARK;
        endcase
        hgrant_d = 4'b0001 << hmsel_d;
        parked_d = (state_d == PARK);
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q  <= PARK;
            hmsel_q  <= DEF_SEL;
            hgrant_q <= 4'b0001 << DEF_SEL;
            parked_q <= 1'b1;
            hold_q   <= '0;
        end else begin
            state_q  <= state_d;
            hmsel_q  <= hmsel_d;
            hgrant_q <= hgrant_d;
            parked_q <= parked_d;
            hold_q   <= hold_d;
        end
    end

    assign HMSEL      = hmsel_q;
    assign HGRANT     = hgrant_q;
    assign ARB_PARKED = parked_q;
endmodule
